// File: rtl/video_stream_rx_checker.sv
// Sink-side monitor for the scaler output stream: rebuilds line/frame position
// from the valid strobe, emits SOF/EOL/EOF markers, per-frame checksum and stall detection.
`timescale 1ns/1ps

module video_stream_rx_checker #(
    parameter int unsigned G_DATA_WIDTH = 8,
    parameter int unsigned G_RES_WIDTH  = 13,
    parameter int unsigned G_TIMEOUT    = 4096
) (
    input  logic                    OUT_VIDEO_CLK_I,
    input  logic                    RESET_I,
    input  logic                    CAPTURE_EN_I,
    input  logic [G_RES_WIDTH-1:0]  HORZ_RES_I,
    input  logic [G_RES_WIDTH-1:0]  VERT_RES_I,
    input  logic                    ERR_CLR_I,
    input  logic                    DATA_VALID_I,
    input  logic [G_DATA_WIDTH-1:0] DATA_R_I,
    input  logic [G_DATA_WIDTH-1:0] DATA_G_I,
    input  logic [G_DATA_WIDTH-1:0] DATA_B_I,
    output logic                    DATA_VALID_O,
    output logic [G_DATA_WIDTH-1:0] DATA_R_O,
    output logic [G_DATA_WIDTH-1:0] DATA_G_O,
    output logic [G_DATA_WIDTH-1:0] DATA_B_O,
    output logic                    SOF_O,
    output logic                    EOL_O,
    output logic                    EOF_O,
    output logic [G_RES_WIDTH-1:0]  H_POS_O,
    output logic [G_RES_WIDTH-1:0]  V_POS_O,
    output logic [15:0]             FRAME_CNT_O,
    output logic [31:0]             FRAME_CHECKSUM_O,
    output logic                    CHECKSUM_VALID_O,
    output logic                    TIMEOUT_ERR_O
);

    localparam int unsigned IDLE_W = $clog2(G_TIMEOUT);
    localparam int unsigned CS_W   = 32;

    typedef enum logic [1:0] {S_IDLE, S_LINE, S_GAP} state_e;

    state_e                  state_q, state_d;
    logic [G_RES_WIDTH-1:0]  h_q, h_d, v_q, v_d;
    logic [G_RES_WIDTH-1:0]  hres_q, hres_d, vres_q, vres_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic [CS_W-1:0]         acc_q, acc_d;

    logic                    valid_q, valid_d;
    logic [G_DATA_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic                    sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic [G_RES_WIDTH-1:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [15:0]             fcnt_q, fcnt_d;
    logic [CS_W-1:0]         cks_q, cks_d;
    logic                    cks_vld_q, cks_vld_d;
    logic                    err_q, err_d;

    logic                    take;
    logic [G_RES_WIDTH-1:0]  cur_h, cur_v, cur_hres, cur_vres;
    logic [CS_W-1:0]         acc_base, acc_new;

    // Next-state, position tracking, checksum and marker generation
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        v_d       = v_q;
        hres_d    = hres_q;
        vres_d    = vres_q;
        idle_d    = idle_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        sof_d     = 1'b0;
        eol_d     = 1'b0;
        eof_d     = 1'b0;
        hpos_d    = hpos_q;
        vpos_d    = vpos_q;
        fcnt_d    = fcnt_q;
        cks_d     = cks_q;
        cks_vld_d = 1'b0;
        err_d     = err_q & ~ERR_CLR_I;
        take      = 1'b0;
        cur_h     = h_q;
        cur_v     = v_q;
        cur_hres  = hres_q;
        cur_vres  = vres_q;
        acc_base  = acc_q;
        acc_new   = acc_q;

        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                if (CAPTURE_EN_I && DATA_VALID_I) begin
                    take     = 1'b1;
                    sof_d    = 1'b1;
                    cur_h    = '0;
                    cur_v    = '0;
                    cur_hres = HORZ_RES_I;
                    cur_vres = VERT_RES_I;
                    hres_d   = HORZ_RES_I;
                    vres_d   = VERT_RES_I;
                    acc_base = '0;
                end
            end
            S_LINE, S_GAP: begin
                if (DATA_VALID_I) begin
                    take   = 1'b1;
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(G_TIMEOUT - 1)) begin
                    // Stall: abandon the partial frame without EOF or count
                    err_d   = 1'b1;
                    idle_d  = '0;
                    h_d     = '0;
                    v_d     = '0;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            valid_d = 1'b1;
            r_d     = DATA_R_I;
            g_d     = DATA_G_I;
            b_d     = DATA_B_I;
            hpos_d  = cur_h;
            vpos_d  = cur_v;
            acc_new = {acc_base[CS_W-2:0], acc_base[CS_W-1]}
                    + CS_W'({DATA_R_I, DATA_G_I, DATA_B_I});
            acc_d   = acc_new;
            if (cur_h == cur_hres - G_RES_WIDTH'(1)) begin
                eol_d   = 1'b1;
                h_d     = '0;
                v_d     = cur_v + G_RES_WIDTH'(1);
                state_d = S_GAP;
                if (cur_v == cur_vres - G_RES_WIDTH'(1)) begin
                    eof_d     = 1'b1;
                    v_d       = '0;
                    fcnt_d    = fcnt_q + 16'd1;
                    cks_d     = acc_new;
                    cks_vld_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end else begin
                h_d     = cur_h + G_RES_WIDTH'(1);
                v_d     = cur_v;
                state_d = S_LINE;
            end
        end
    end

    always_ff @(posedge OUT_VIDEO_CLK_I) begin
        if (RESET_I) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            hres_q    <= '0;
            vres_q    <= '0;
            idle_q    <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
            hpos_q    <= '0;
            vpos_q    <= '0;
            fcnt_q    <= '0;
            cks_q     <= '0;
            cks_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hres_q    <= hres_d;
            vres_q    <= vres_d;
            idle_q    <= idle_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
            eof_q     <= eof_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            fcnt_q    <= fcnt_d;
            cks_q     <= cks_d;
            cks_vld_q <= cks_vld_d;
            err_q     <= err_d;
        end
    end

    assign DATA_VALID_O     = valid_q;
    assign DATA_R_O         = r_q;
    assign DATA_G_O         = g_q;
    assign DATA_B_O         = b_q;
    assign SOF_O            = sof_q;
    assign EOL_O            = eol_q;
    assign EOF_O            = eof_q;
    assign H_POS_O          = hpos_q;
    assign V_POS_O          = vpos_q;
    assign FRAME_CNT_O      = fcnt_q;
    assign FRAME_CHECKSUM_O = cks_q;
    assign CHECKSUM_VALID_O = cks_vld_q;
    assign TIMEOUT_ERR_O    = err_q;

endmodule

// File: tb/tb_video_stream_rx_checker.sv
// Bench for video_stream_rx_checker: frame-index reference model compared every cycle,
// directed scenarios with literal expectations, then randomized streams.
`timescale 1ns/1ps

module tb_video_stream_rx_checker;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [12:0] hres_i = 13'd4;
    logic [12:0] vres_i = 13'd3;
    logic        err_clr = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  ri = 8'd0, gi = 8'd0, bi = 8'd0;

    logic        valid_o, sof_o, eol_o, eof_o, cv_o, err_o;
    logic [7:0]  ro, go, bo;
    logic [12:0] hpos_o, vpos_o;
    logic [15:0] fcnt_o;
    logic [31:0] cks_o;

    int n_tests = 0;
    int n_fail  = 0;

    video_stream_rx_checker #(.G_DATA_WIDTH(8), .G_RES_WIDTH(13), .G_TIMEOUT(TO)) dut (
        .OUT_VIDEO_CLK_I(clk), .RESET_I(rst), .CAPTURE_EN_I(en),
        .HORZ_RES_I(hres_i), .VERT_RES_I(vres_i), .ERR_CLR_I(err_clr),
        .DATA_VALID_I(dv), .DATA_R_I(ri), .DATA_G_I(gi), .DATA_B_I(bi),
        .DATA_VALID_O(valid_o), .DATA_R_O(ro), .DATA_G_O(go), .DATA_B_O(bo),
        .SOF_O(sof_o), .EOL_O(eol_o), .EOF_O(eof_o),
        .H_POS_O(hpos_o), .V_POS_O(vpos_o), .FRAME_CNT_O(fcnt_o),
        .FRAME_CHECKSUM_O(cks_o), .CHECKSUM_VALID_O(cv_o), .TIMEOUT_ERR_O(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: a frame is a flat pixel index n; position is n mod/div HRES
    bit          m_active = 0;
    int          m_n = 0, m_hres = 1, m_vres = 1, m_idle = 0;
    logic [31:0] m_acc = 0;
    bit          e_valid = 0, e_sof = 0, e_eol = 0, e_eof = 0, e_cv = 0, e_err = 0;
    logic [7:0]  e_r = 0, e_g = 0, e_b = 0;
    int          e_h = 0, e_v = 0;
    logic [15:0] e_fcnt = 0;
    logic [31:0] e_cks = 0;

    task automatic model_step();
        bit take, new_err;
        logic [31:0] pix;
        take = 0;
        new_err = 0;
        if (rst) begin
            m_active = 0; m_n = 0; m_idle = 0; m_acc = 0;
            e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_cv = 0; e_err = 0;
            e_r = 0; e_g = 0; e_b = 0; e_h = 0; e_v = 0; e_fcnt = 0; e_cks = 0;
            return;
        end
        e_valid = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_cv = 0;
        if (!m_active) begin
            if (en && dv) begin
                m_active = 1; m_n = 0; m_idle = 0; m_acc = 0;
                m_hres = int'(hres_i); m_vres = int'(vres_i);
                take = 1;
            end
        end else if (dv) begin
            take = 1;
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                new_err = 1;
                m_active = 0;
                m_idle = 0;
            end
        end
        if (take) begin
            pix = {8'h00, ri, gi, bi};
            e_valid = 1; e_r = ri; e_g = gi; e_b = bi;
            e_h = m_n % m_hres;
            e_v = m_n / m_hres;
            e_sof = (m_n == 0);
            e_eol = (e_h == m_hres - 1);
            m_acc = ((m_acc << 1) | (m_acc >> 31)) + pix;
            if (m_n == m_hres * m_vres - 1) begin
                e_eof = 1; e_cv = 1; e_cks = m_acc; e_fcnt = e_fcnt + 16'd1;
                m_active = 0;
            end
            m_n++;
        end
        if (new_err)      e_err = 1;
        else if (err_clr) e_err = 0;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("valid", 32'(valid_o), 32'(e_valid));
        chk("sof",   32'(sof_o),   32'(e_sof));
        chk("eol",   32'(eol_o),   32'(e_eol));
        chk("eof",   32'(eof_o),   32'(e_eof));
        chk("ckvld", 32'(cv_o),    32'(e_cv));
        chk("fcnt",  32'(fcnt_o),  32'(e_fcnt));
        chk("cksum", cks_o,        e_cks);
        chk("err",   32'(err_o),   32'(e_err));
        if (e_valid) begin
            chk("pixel", {8'h00, ro, go, bo}, {8'h00, e_r, e_g, e_b});
            chk("hpos",  32'(hpos_o), 32'(e_h));
            chk("vpos",  32'(vpos_o), 32'(e_v));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dv = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic send(input logic [7:0] v);
        dv = 1; ri = v; gi = v; bi = v;
        cyc();
        dv = 0;
    endtask

    // 4x3 frame of pixels {n,n,n}, optional gap after each line
    task automatic frame43(input int gap);
        for (int n = 0; n < 12; n++) begin
            send(8'(n));
            if (n % 4 == 3 && n != 11) idle(gap);
        end
    endtask

    localparam logic [31:0] CKS43 = 32'h100302F3;

    initial begin
        idle(3);
        rst = 0;
        cyc();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_fcnt",  32'(fcnt_o),  32'd0);
        chk("rst_cksum", cks_o,        32'd0);

        // 1: contiguous 4x3
        en = 1; hres_i = 4; vres_i = 3;
        frame43(0);
        chk("t1_eof",   32'(eof_o), 32'd1);
        chk("t1_cksum", cks_o,      CKS43);
        chk("t1_fcnt",  32'(fcnt_o), 32'd1);
        idle(2);

        // 2: 20-cycle inter-line gaps
        frame43(20);
        chk("t2_cksum", cks_o,       CKS43);
        chk("t2_fcnt",  32'(fcnt_o), 32'd2);
        idle(2);

        // 3: truncated frame -> stall
        for (int n = 0; n < 8; n++) send(8'(n));
        idle(TO - 1);
        chk("t3_noerr", 32'(err_o), 32'd0);
        idle(1);
        chk("t3_err",   32'(err_o),  32'd1);
        chk("t3_fcnt",  32'(fcnt_o), 32'd2);
        err_clr = 1; cyc(); err_clr = 0;
        chk("t3_clr",   32'(err_o), 32'd0);
        frame43(0);
        chk("t3_fcnt2", 32'(fcnt_o), 32'd3);
        idle(2);

        // 4: 1x1 frame
        hres_i = 1; vres_i = 1;
        dv = 1; ri = 8'h05; gi = 8'h06; bi = 8'h07; cyc(); dv = 0;
        chk("t4_markers", {29'd0, sof_o, eol_o, eof_o}, 32'd7);
        chk("t4_cksum",   cks_o, 32'h00050607);
        idle(2);

        // 5: disabled valids dropped; mid-frame HRES change ignored
        hres_i = 4; vres_i = 3; en = 0;
        for (int n = 0; n < 12; n++) begin
            send(8'(n));
            chk("t5_drop", 32'(valid_o), 32'd0);
        end
        en = 1;
        for (int n = 0; n < 12; n++) begin
            if (n == 5) hres_i = 2;
            send(8'(n));
        end
        chk("t5_eof",  32'(eof_o),  32'd1);
        chk("t5_fcnt", 32'(fcnt_o), 32'd5);
        hres_i = 4;
        idle(2);

        // 6: reset mid-frame
        for (int n = 0; n < 6; n++) send(8'(n));
        rst = 1; dv = 1; cyc(); dv = 0; rst = 0;
        chk("t6_valid", 32'(valid_o), 32'd0);
        chk("t6_fcnt",  32'(fcnt_o),  32'd0);
        chk("t6_cksum", cks_o,        32'd0);
        frame43(0);
        chk("t6_fcnt2", 32'(fcnt_o), 32'd1);
        chk("t6_cksum2", cks_o,      CKS43);
        idle(2);

        // Randomized streams: sizes, gaps, enable/res jitter, stalls, error clears
        for (int f = 0; f < 40; f++) begin
            int tot;
            bit stall;
            hres_i = 13'($urandom_range(1, 5));
            vres_i = 13'($urandom_range(1, 4));
            en = ($urandom_range(0, 3) != 0);
            tot = int'(hres_i) * int'(vres_i);
            stall = ($urandom_range(0, 6) == 0);
            for (int p = 0; p < tot; p++) begin
                if (stall && p == tot / 2) begin
                    idle(TO + 2);
                    break;
                end
                dv = 1;
                ri = 8'($urandom); gi = 8'($urandom); bi = 8'($urandom);
                err_clr = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) en = ~en;
                if ($urandom_range(0, 9) == 0) hres_i = 13'($urandom_range(1, 5));
                cyc();
                dv = 0;
                err_clr = 0;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 10));
            end
            idle($urandom_range(0, 2));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
